// File: rtl/video_test_pattern_gen.sv
// Raw-Bayer test-pattern source with a WISHBONE register file, feeding an AXI4-Stream video sink.
// Optional macro VIDEO_TPG_FRAME_LIMIT_EN adds PARAM_FRAME_NUM (0x14) to stop after N frames.
module video_test_pattern_gen #(
   parameter int         WB_ADR_WIDTH       = 8,
   parameter int         WB_DAT_WIDTH       = 64,
   parameter int         WB_SEL_WIDTH       = WB_DAT_WIDTH / 8,
   parameter int         TDATA_WIDTH        = 10,
   parameter int         X_WIDTH            = 16,
   parameter int         Y_WIDTH            = 16,
   parameter logic [1:0] INIT_CTL_CONTROL   = 2'b00,
   parameter int         INIT_PARAM_WIDTH   = 1024,
   parameter int         INIT_PARAM_HEIGHT  = 64,
   parameter int         INIT_PARAM_PATTERN = 0,
   parameter int         INIT_PARAM_VBLANK  = 16
) (
   input  logic                    reset,
   input  logic                    clk,
   input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
   output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
   input  logic                    s_wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
   input  logic                    s_wb_stb_i,
   output logic                    s_wb_ack_o,
   output logic                    m_axi4s_tuser,
   output logic                    m_axi4s_tlast,
   output logic [TDATA_WIDTH-1:0]  m_axi4s_tdata,
   output logic                    m_axi4s_tvalid,
   input  logic                    m_axi4s_tready
);

   localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID   = WB_ADR_WIDTH'('h00);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL   = WB_ADR_WIDTH'('h04);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS    = WB_ADR_WIDTH'('h05);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_INDEX     = WB_ADR_WIDTH'('h07);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_WIDTH     = WB_ADR_WIDTH'('h10);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_HEIGHT    = WB_ADR_WIDTH'('h11);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_PATTERN   = WB_ADR_WIDTH'('h12);
   localparam logic [WB_ADR_WIDTH-1:0] ADR_VBLANK    = WB_ADR_WIDTH'('h13);
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
   localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAME_NUM = WB_ADR_WIDTH'('h14);
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_BLANK} state_t;

   state_t               state_q, state_d;
   logic [X_WIDTH-1:0]   x_q, x_d, width_q, width_d, width_sh_q, width_sh_d, w_last;
   logic [Y_WIDTH-1:0]   y_q, y_d, height_q, height_d, height_sh_q, height_sh_d, h_last;
   logic [31:0]          pattern_q, pattern_d, pattern_sh_q, pattern_sh_d;
   logic [31:0]          vblank_q, vblank_d, vblank_sh_q, vblank_sh_d, vb_last;
   logic [31:0]          blank_q, blank_d, index_q, index_d, sum_v;
   logic [1:0]           ctl_q, ctl_d;
   logic                 load_shadow, wr_en, busy;
   logic [WB_DAT_WIDTH-1:0] wr_mask;
   logic [TDATA_WIDTH-1:0]  pix;
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
   logic [31:0]          frame_num_q, frame_num_d, frame_num_sh_q, frame_num_sh_d;
   logic [31:0]          frame_cnt_q, frame_cnt_d;
`endif

   for (genvar gi = 0; gi < WB_SEL_WIDTH; gi++) begin : g_wr_mask
      assign wr_mask[gi*8 +: 8] = {8{s_wb_sel_i[gi]}};
   end

   function automatic logic [WB_DAT_WIDTH-1:0] merge(input logic [WB_DAT_WIDTH-1:0] old_v,
                                                     input logic [WB_DAT_WIDTH-1:0] new_v,
                                                     input logic [WB_DAT_WIDTH-1:0] mask_v);
      return (old_v & ~mask_v) | (new_v & mask_v);
   endfunction

   assign wr_en      = s_wb_stb_i & s_wb_we_i;
   assign s_wb_ack_o = s_wb_stb_i;
   assign busy       = (state_q != ST_IDLE);

   // A programmed size of zero behaves as one.
   assign w_last  = (width_sh_q == '0) ? '0 : width_sh_q - X_WIDTH'(1);
   assign h_last  = (height_sh_q == '0) ? '0 : height_sh_q - Y_WIDTH'(1);
   assign vb_last = (vblank_sh_q == '0) ? '0 : vblank_sh_q - 32'd1;
   assign sum_v   = 32'(x_q) + 32'(y_q) + 32'(index_q[7:0]);

   always_comb begin
      case (pattern_sh_q)
         32'd1:   pix = TDATA_WIDTH'(y_q);
         32'd2:   pix = (x_q[3] ^ y_q[3]) ? '1 : '0;
         32'd3:   pix = TDATA_WIDTH'(sum_v);
         default: pix = TDATA_WIDTH'(x_q);
      endcase
   end

   assign m_axi4s_tvalid = (state_q == ST_ACTIVE);
   assign m_axi4s_tuser  = m_axi4s_tvalid && (x_q == '0) && (y_q == '0);
   assign m_axi4s_tlast  = m_axi4s_tvalid && (x_q == w_last);
   assign m_axi4s_tdata  = m_axi4s_tvalid ? pix : '0;

   always_comb begin
      s_wb_dat_o = '0;
      case (s_wb_adr_i)
         ADR_CORE_ID:   s_wb_dat_o = WB_DAT_WIDTH'(32'h527A_1F40);
         ADR_CONTROL:   s_wb_dat_o = WB_DAT_WIDTH'(ctl_q);
         ADR_STATUS:    s_wb_dat_o = WB_DAT_WIDTH'(busy);
         ADR_INDEX:     s_wb_dat_o = WB_DAT_WIDTH'(index_q);
         ADR_WIDTH:     s_wb_dat_o = WB_DAT_WIDTH'(width_q);
         ADR_HEIGHT:    s_wb_dat_o = WB_DAT_WIDTH'(height_q);
         ADR_PATTERN:   s_wb_dat_o = WB_DAT_WIDTH'(pattern_q);
         ADR_VBLANK:    s_wb_dat_o = WB_DAT_WIDTH'(vblank_q);
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
         ADR_FRAME_NUM: s_wb_dat_o = WB_DAT_WIDTH'(frame_num_q);
`endif
         default:       s_wb_dat_o = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      blank_d      = blank_q;
      index_d      = index_q;
      ctl_d        = ctl_q;
      width_d      = width_q;
      height_d     = height_q;
      pattern_d    = pattern_q;
      vblank_d     = vblank_q;
      width_sh_d   = width_sh_q;
      height_sh_d  = height_sh_q;
      pattern_sh_d = pattern_sh_q;
      vblank_sh_d  = vblank_sh_q;
      load_shadow  = 1'b0;
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
      frame_num_d    = frame_num_q;
      frame_num_sh_d = frame_num_sh_q;
      frame_cnt_d    = ctl_q[0] ? frame_cnt_q : '0;
`endif
      case (state_q)
         ST_IDLE: begin
            load_shadow = ctl_q[1];
            if (ctl_q[0]) begin
               state_d = ST_ACTIVE;
               x_d     = '0;
               y_d     = '0;
            end
         end
         ST_ACTIVE: begin
            if (m_axi4s_tready) begin
               if (x_q == w_last) begin
                  x_d = '0;
                  if (y_q == h_last) begin
                     y_d     = '0;
                     index_d = index_q + 32'd1;
                     blank_d = '0;
                     state_d = ST_BLANK;
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
                     if (ctl_q[0] && frame_num_sh_q != '0 && frame_cnt_q + 32'd1 >= frame_num_sh_q) begin
                        ctl_d[0]    = 1'b0;
                        frame_cnt_d = '0;
                     end else if (ctl_q[0]) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                     end
`endif
                  end else begin
                     y_d = y_q + Y_WIDTH'(1);
                  end
               end else begin
                  x_d = x_q + X_WIDTH'(1);
               end
            end
         end
         ST_BLANK: begin
            if (blank_q >= vb_last) begin
               if (ctl_q[0]) begin
                  state_d     = ST_ACTIVE;
                  x_d         = '0;
                  y_d         = '0;
                  load_shadow = ctl_q[1];
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               blank_d = blank_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_shadow) begin
         width_sh_d   = width_q;
         height_sh_d  = height_q;
         pattern_sh_d = pattern_q;
         vblank_sh_d  = vblank_q;
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
         frame_num_sh_d = frame_num_q;
`endif
         ctl_d[1] = 1'b0;
      end

      // A bus write in the same cycle overrides any auto-clear of CONTROL.
      if (wr_en) begin
         case (s_wb_adr_i)
            ADR_CONTROL: ctl_d     = 2'(merge(WB_DAT_WIDTH'(ctl_q), s_wb_dat_i, wr_mask));
            ADR_WIDTH:   width_d   = X_WIDTH'(merge(WB_DAT_WIDTH'(width_q), s_wb_dat_i, wr_mask));
            ADR_HEIGHT:  height_d  = Y_WIDTH'(merge(WB_DAT_WIDTH'(height_q), s_wb_dat_i, wr_mask));
            ADR_PATTERN: pattern_d = 32'(merge(WB_DAT_WIDTH'(pattern_q), s_wb_dat_i, wr_mask));
            ADR_VBLANK:  vblank_d  = 32'(merge(WB_DAT_WIDTH'(vblank_q), s_wb_dat_i, wr_mask));
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
            ADR_FRAME_NUM: frame_num_d = 32'(merge(WB_DAT_WIDTH'(frame_num_q), s_wb_dat_i, wr_mask));
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         blank_q      <= '0;
         index_q      <= '0;
         ctl_q        <= INIT_CTL_CONTROL;
         width_q      <= X_WIDTH'(INIT_PARAM_WIDTH);
         height_q     <= Y_WIDTH'(INIT_PARAM_HEIGHT);
         pattern_q    <= 32'(INIT_PARAM_PATTERN);
         vblank_q     <= 32'(INIT_PARAM_VBLANK);
         width_sh_q   <= X_WIDTH'(INIT_PARAM_WIDTH);
         height_sh_q  <= Y_WIDTH'(INIT_PARAM_HEIGHT);
         pattern_sh_q <= 32'(INIT_PARAM_PATTERN);
         vblank_sh_q  <= 32'(INIT_PARAM_VBLANK);
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
         frame_num_q    <= '0;
         frame_num_sh_q <= '0;
         frame_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         blank_q      <= blank_d;
         index_q      <= index_d;
         ctl_q        <= ctl_d;
         width_q      <= width_d;
         height_q     <= height_d;
         pattern_q    <= pattern_d;
         vblank_q     <= vblank_d;
         width_sh_q   <= width_sh_d;
         height_sh_q  <= height_sh_d;
         pattern_sh_q <= pattern_sh_d;
         vblank_sh_q  <= vblank_sh_d;
`ifdef VIDEO_TPG_FRAME_LIMIT_EN
         frame_num_q    <= frame_num_d;
         frame_num_sh_q <= frame_num_sh_d;
         frame_cnt_q    <= frame_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// Self-checking bench for video_test_pattern_gen: directed register steps, random tready and
// random frame geometry checked against a raster/pattern reference model.
module tb_video_test_pattern_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  adr;
   logic [63:0] wdat;
   logic [63:0] rdat_o;
   logic        we, stb, ack;
   logic [7:0]  sel;
   logic        tuser, tlast, tvalid, tready;
   logic [9:0]  tdata;

   always #5 clk = ~clk;

   video_test_pattern_gen dut (
      .reset          (reset),
      .clk            (clk),
      .s_wb_adr_i     (adr),
      .s_wb_dat_o     (rdat_o),
      .s_wb_dat_i     (wdat),
      .s_wb_we_i      (we),
      .s_wb_sel_i     (sel),
      .s_wb_stb_i     (stb),
      .s_wb_ack_o     (ack),
      .m_axi4s_tuser  (tuser),
      .m_axi4s_tlast  (tlast),
      .m_axi4s_tdata  (tdata),
      .m_axi4s_tvalid (tvalid),
      .m_axi4s_tready (tready)
   );

   typedef struct {
      logic       u;
      logic       l;
      logic [9:0] d;
      int         cyc;
   } beat_t;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    mode = 1;   // 0: tready low, 1: tready high, 2: random
   beat_t beat_q[$];
   int    rise_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference pixel model straight from the pattern rules.
   function automatic int exp_pix(input int pat, input int x, input int y, input int idx);
      int f = idx % 256;
      case (pat)
         1:       return y % 1024;
         2:       return (((x / 8) ^ (y / 8)) % 2 == 1) ? 1023 : 0;
         3:       return (x + y + f) % 1024;
         default: return x % 1024;
      endcase
   endfunction

   // Stream monitor: records accepted beats and tvalid rises, checks stall stability.
   initial begin
      logic       prev_stall = 1'b0;
      logic       prev_tv = 1'b0;
      logic       prev_u = 1'b0;
      logic       prev_l = 1'b0;
      logic [9:0] prev_d = '0;
      beat_t      b;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            prev_stall = 1'b0;
            prev_tv    = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_tvalid", 64'(tvalid), 64'd1);
               check("stall_tdata", 64'(tdata), 64'(prev_d));
               check("stall_tuser", 64'(tuser), 64'(prev_u));
               check("stall_tlast", 64'(tlast), 64'(prev_l));
            end
            if (tvalid && !prev_tv) rise_q.push_back(cyc);
            if (tvalid && tready) begin
               b.u = tuser; b.l = tlast; b.d = tdata; b.cyc = cyc;
               beat_q.push_back(b);
            end
            prev_stall = tvalid && !tready;
            prev_tv    = tvalid;
            prev_u     = tuser;
            prev_l     = tlast;
            prev_d     = tdata;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      stb = 1'b0;
      we  = 1'b0;
      case (mode)
         0:       tready = 1'b0;
         1:       tready = 1'b1;
         default: tready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic wb_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s = 8'hFF);
      step();
      adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1;
   endtask

   task automatic wb_read(input logic [7:0] a, output logic [63:0] d);
      step();
      adr = a; we = 1'b0; sel = 8'hFF; stb = 1'b1;
      #2;
      check("wb_ack", 64'(ack), 64'd1);
      d = rdat_o;
   endtask

   task automatic read_check(input string tag, input logic [7:0] a, input logic [63:0] exp);
      logic [63:0] d;
      wb_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic wait_rise(input int n);
      int g = 0;
      while (rise_q.size() < n && g < 200) begin
         step();
         g++;
      end
      check("rise_seen", 64'(rise_q.size() >= n), 64'd1);
   endtask

   task automatic expect_frame(input int w, input int h, input int pat, input int idx,
                               output int last_cyc);
      int    weff = (w == 0) ? 1 : w;
      int    heff = (h == 0) ? 1 : h;
      beat_t b;
      last_cyc = 0;
      for (int y = 0; y < heff; y++) begin
         for (int x = 0; x < weff; x++) begin
            int g = 0;
            while (beat_q.size() == 0 && g < 100) begin
               step();
               g++;
            end
            if (beat_q.size() == 0) begin
               check($sformatf("beat_avail f%0d (%0d,%0d)", idx, x, y), 64'(beat_q.size() != 0), 64'd1);
               return;
            end
            b = beat_q.pop_front();
            check($sformatf("tdata f%0d (%0d,%0d)", idx, x, y), 64'(b.d), 64'(exp_pix(pat, x, y, idx)));
            check($sformatf("tuser f%0d (%0d,%0d)", idx, x, y), 64'(b.u), 64'(x == 0 && y == 0));
            check($sformatf("tlast f%0d (%0d,%0d)", idx, x, y), 64'(b.l), 64'(x == weff - 1));
            last_cyc = b.cyc;
         end
      end
   endtask

   initial begin
      int last;
      int nr;
      int idx;
      int w, h, pat, vb;
      adr = '0; wdat = '0; we = 1'b0; stb = 1'b0; sel = '0; tready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #3;
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tdata", 64'(tdata), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mode  = 1;

      read_check("core_id", 8'h00, 64'h527A_1F40);
      read_check("init_control", 8'h04, 64'd0);
      read_check("init_status", 8'h05, 64'd0);
      read_check("init_index", 8'h07, 64'd0);
      read_check("init_width", 8'h10, 64'd1024);
      read_check("init_height", 8'h11, 64'd64);
      read_check("init_pattern", 8'h12, 64'd0);
      read_check("init_vblank", 8'h13, 64'd16);
      read_check("unmapped_06", 8'h06, 64'd0);
`ifndef VIDEO_TPG_FRAME_LIMIT_EN
      read_check("unmapped_14", 8'h14, 64'd0);
`endif
      step();
      #2;
      check("ack_idle", 64'(ack), 64'd0);

      // Byte enables: only byte 0 of VBLANK is replaced
      wb_write(8'h13, 64'h0000_0000_0000_1122, 8'h01);
      read_check("vblank_bytesel", 8'h13, 64'h22);
      wb_write(8'h13, 64'd16);

      // First frame: W=8, H=2, pattern 0, tready high
      wb_write(8'h10, 64'd8);
      wb_write(8'h11, 64'd2);
      wb_write(8'h12, 64'd0);
      beat_q.delete();
      rise_q.delete();
      wb_write(8'h04, 64'd3);
      expect_frame(8, 2, 0, 0, last);
      read_check("index_after_f0", 8'h07, 64'd1);
      read_check("busy_blank", 8'h05, 64'd1);
      wait_rise(2);
      if (rise_q.size() >= 2) check("vblank_gap", 64'(rise_q[1] - last), 64'd17);

      // Width change without update stays pending; update request takes it at the boundary
      wb_write(8'h10, 64'd4);
      wb_write(8'h04, 64'd3);
      mode = 2;
      expect_frame(8, 2, 0, 1, last);
      expect_frame(4, 2, 0, 2, last);
      read_check("control_autoclear", 8'h04, 64'd1);
      read_check("width_readback", 8'h10, 64'd4);

      // Pattern 3 at full width, enable dropped mid-frame
      mode = 1;
      wb_write(8'h12, 64'd3);
      wb_write(8'h10, 64'd1024);
      wb_write(8'h11, 64'd2);
      nr = rise_q.size();
      wb_write(8'h04, 64'd3);
      wait_rise(nr + 1);
      wb_write(8'h04, 64'd0);
      mode = 2;
      expect_frame(1024, 2, 3, 3, last);
      repeat (25) step();
      read_check("busy_after_disable", 8'h05, 64'd0);
      check("no_extra_beats", 64'(beat_q.size()), 64'd0);
      read_check("index_after_f3", 8'h07, 64'd4);

      // Random single frames from IDLE, including zero width / zero height
      idx = 4;
      for (int it = 0; it < 5; it++) begin
         w   = (it == 0) ? 0 : int'($urandom_range(1, 20));
         h   = (it == 1) ? 0 : int'($urandom_range(1, 3));
         pat = int'($urandom_range(0, 5));
         vb  = int'($urandom_range(0, 3));
         wb_write(8'h10, 64'(w));
         wb_write(8'h11, 64'(h));
         wb_write(8'h12, 64'(pat));
         wb_write(8'h13, 64'(vb));
         mode = 0;
         nr = rise_q.size();
         wb_write(8'h04, 64'd3);
         wait_rise(nr + 1);
         wb_write(8'h04, 64'd0);
         mode = 2;
         expect_frame(w, h, pat, idx, last);
         repeat (vb + 4) step();
         read_check($sformatf("idle_after_rand%0d", it), 8'h05, 64'd0);
         check($sformatf("no_extra_rand%0d", it), 64'(beat_q.size()), 64'd0);
         idx++;
      end

      // Asynchronous reset during a stalled ACTIVE frame
      wb_write(8'h10, 64'd8);
      wb_write(8'h11, 64'd2);
      wb_write(8'h12, 64'd1);
      mode = 0;
      nr = rise_q.size();
      wb_write(8'h04, 64'd3);
      wait_rise(nr + 1);
      #2;
      check("pre_reset_tvalid", 64'(tvalid), 64'd1);
      reset = 1'b1;
      #1;
      check("async_rst_tvalid", 64'(tvalid), 64'd0);
      check("async_rst_tuser", 64'(tuser), 64'd0);
      check("async_rst_tlast", 64'(tlast), 64'd0);
      check("async_rst_tdata", 64'(tdata), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      beat_q.delete();
      rise_q.delete();
      read_check("post_rst_control", 8'h04, 64'd0);
      read_check("post_rst_width", 8'h10, 64'd1024);
      read_check("post_rst_height", 8'h11, 64'd64);
      read_check("post_rst_pattern", 8'h12, 64'd0);
      read_check("post_rst_vblank", 8'h13, 64'd16);
      read_check("post_rst_index", 8'h07, 64'd0);
      read_check("post_rst_status", 8'h05, 64'd0);

`ifdef VIDEO_TPG_FRAME_LIMIT_EN
      // Frame limit: exactly three frames, then idle with enable cleared
      begin
         int n_user = 0;
         wb_write(8'h14, 64'd3);
         wb_write(8'h10, 64'd4);
         wb_write(8'h11, 64'd1);
         wb_write(8'h13, 64'd2);
         mode = 1;
         wb_write(8'h04, 64'd3);
         repeat (120) step();
         foreach (beat_q[i]) if (beat_q[i].u) n_user++;
         check("frame_limit_tuser", 64'(n_user), 64'd3);
         read_check("frame_limit_busy", 8'h05, 64'd0);
         read_check("frame_limit_control", 8'h04, 64'd0);
         read_check("frame_limit_index", 8'h07, 64'd3);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
